// File: rtl/wavelet_fir_mac_if.sv
// ---------------------------------------------------------------------------
// wavelet_fir_mac_if
//   Handshake and data bundle for one wavelet FIR channel.
//
//   Signals (named from the filter's point of view):
//     i_sample        signed input sample
//     i_sample_valid  sample offered this cycle
//     i_coeffs        packed signed coefficients, tap k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//     o_ready         filter idle, next offered sample will be accepted
//     o_truncated     signed, shifted and saturated filter result
//     o_valid         one-cycle pulse when o_truncated updates
//     o_busy          filter is running its multiply-accumulate
//     o_dropped       one-cycle pulse for a sample offered while busy
//
//   Modports:
//     master  sample source / result consumer (drives i_*)
//     slave   the filter itself (drives o_*)
// ---------------------------------------------------------------------------
interface wavelet_fir_mac_if #(
  parameter int NUM_TAPS       = 8,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int COEFF_WIDTH    = 8,
  parameter int SUM_TRUNCATION = 8
);

  logic signed [SAMPLE_WIDTH-1:0]         i_sample;
  logic                                   i_sample_valid;
  logic        [NUM_TAPS*COEFF_WIDTH-1:0] i_coeffs;
  logic                                   o_ready;
  logic signed [SUM_TRUNCATION-1:0]       o_truncated;
  logic                                   o_valid;
  logic                                   o_busy;
  logic                                   o_dropped;

  modport master (
    output i_sample,
    output i_sample_valid,
    output i_coeffs,
    input  o_ready,
    input  o_truncated,
    input  o_valid,
    input  o_busy,
    input  o_dropped
  );

  modport slave (
    input  i_sample,
    input  i_sample_valid,
    input  i_coeffs,
    output o_ready,
    output o_truncated,
    output o_valid,
    output o_busy,
    output o_dropped
  );

endinterface

// File: rtl/wavelet_fir_mac.sv
// ---------------------------------------------------------------------------
// wavelet_fir_mac
//   One wavelet filter channel. Each accepted sample is pushed into a
//   NUM_TAPS-deep delay line and the coefficient set is captured. The filter
//   then walks the taps one per cycle, accumulating c[k]*x[k] at full
//   precision, and finally arithmetic-shifts the sum right by OUT_SHIFT and
//   saturates it to SUM_TRUNCATION signed bits.
//
//   Timing: accept edge E0, MAC edges E1..E(NUM_TAPS); the result and its
//   o_valid pulse appear after E(NUM_TAPS). The next sample can be accepted
//   at E(NUM_TAPS+1).
//
//   Ports:
//     clk   clock, everything on the rising edge
//     rst   synchronous reset, active low; aborts any running MAC silently
//     bus   wavelet_fir_mac_if.slave (sample/coeff inputs, result/status outputs)
// ---------------------------------------------------------------------------
module wavelet_fir_mac #(
  parameter int NUM_TAPS       = 8,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int COEFF_WIDTH    = 8,
  parameter int SUM_TRUNCATION = 8,
  parameter int OUT_SHIFT      = 8
) (
  input  logic              clk,
  input  logic              rst,
  wavelet_fir_mac_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Derived widths
  // -------------------------------------------------------------------------
  localparam int PROD_W = SAMPLE_WIDTH + COEFF_WIDTH;
  // clog2(NUM_TAPS) guard bits: a sum of NUM_TAPS full-scale products fits.
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int IDX_W  = $clog2(NUM_TAPS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  // Saturation bounds expressed at accumulator width so the comparison is a
  // plain signed compare against the shifted sum.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-SUM_TRUNCATION+1){1'b0}}, {(SUM_TRUNCATION-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-SUM_TRUNCATION+1){1'b1}}, {(SUM_TRUNCATION-1){1'b0}}});

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  // -------------------------------------------------------------------------
  // Datapath state
  // -------------------------------------------------------------------------
  logic signed [SAMPLE_WIDTH-1:0]   x_reg     [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]    coeff_reg [NUM_TAPS];
  logic signed [ACC_W-1:0]          acc_reg;
  logic        [IDX_W-1:0]          idx_reg;
  logic signed [SUM_TRUNCATION-1:0] trunc_reg;
  logic                             valid_reg;
  logic                             dropped_reg;

  // Combinational helpers
  logic signed [SAMPLE_WIDTH-1:0]   x_shift  [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]    coeff_in [NUM_TAPS];
  logic signed [SAMPLE_WIDTH-1:0]   x_tap;
  logic signed [COEFF_WIDTH-1:0]    c_tap;
  logic signed [PROD_W-1:0]         x_ext;
  logic signed [PROD_W-1:0]         c_ext;
  logic signed [PROD_W-1:0]         product;
  logic signed [ACC_W-1:0]          acc_sum;
  logic signed [ACC_W-1:0]          shifted;
  logic signed [SUM_TRUNCATION-1:0] sat_result;
  logic                             accept;
  logic                             last_tap;

  assign accept   = (state_reg == IDLE) && bus.i_sample_valid;
  assign last_tap = (state_reg == MAC) && (idx_reg == LAST_IDX);

  // -------------------------------------------------------------------------
  // Delay-line shift pattern and coefficient unpacking
  // -------------------------------------------------------------------------
  assign x_shift[0] = bus.i_sample;

  for (genvar gi = 1; gi < NUM_TAPS; gi++) begin : g_shift
    assign x_shift[gi] = x_reg[gi-1];
  end

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_coeff
    assign coeff_in[gi] = $signed(bus.i_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH]);
  end

  // -------------------------------------------------------------------------
  // Multiply-accumulate for the current tap
  // -------------------------------------------------------------------------
  assign x_tap = x_reg[idx_reg];
  assign c_tap = coeff_reg[idx_reg];

  // Both operands sign-extended to the full product width before multiplying.
  assign x_ext   = $signed({{COEFF_WIDTH{x_tap[SAMPLE_WIDTH-1]}}, x_tap});
  assign c_ext   = $signed({{SAMPLE_WIDTH{c_tap[COEFF_WIDTH-1]}}, c_tap});
  assign product = x_ext * c_ext;

  assign acc_sum = acc_reg
                 + $signed({{(ACC_W-PROD_W){product[PROD_W-1]}}, product});

  // Arithmetic shift: floors toward -inf for negative sums.
  assign shifted = acc_sum >>> OUT_SHIFT;

  always_comb begin
    sat_result = shifted[SUM_TRUNCATION-1:0];
    if (shifted > SAT_MAX) begin
      sat_result = SAT_MAX[SUM_TRUNCATION-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_result = SAT_MIN[SUM_TRUNCATION-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_sample_valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    bus.o_ready = 1'b0;
    bus.o_busy  = 1'b0;
    case (state_reg)
      IDLE:    bus.o_ready = 1'b1;
      MAC:     bus.o_busy  = 1'b1;
      default: bus.o_ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Delay line and coefficient capture: both only move on an accept, so a
  // sample offered while busy and any coefficient change during MAC are
  // invisible to the running computation.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_reg[k]     <= '0;
        coeff_reg[k] <= '0;
      end
    end else if (accept) begin
      x_reg     <= x_shift;
      coeff_reg <= coeff_in;
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator, tap index, result register and status pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg     <= '0;
      idx_reg     <= '0;
      trunc_reg   <= '0;
      valid_reg   <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      dropped_reg <= (state_reg == MAC) && bus.i_sample_valid;

      if (accept) begin
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (state_reg == MAC) begin
        acc_reg <= acc_sum;
        if (last_tap) begin
          // Result includes the final product, hence acc_sum not acc_reg.
          idx_reg   <= '0;
          trunc_reg <= sat_result;
          valid_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign bus.o_truncated = trunc_reg;
  assign bus.o_valid     = valid_reg;
  assign bus.o_dropped   = dropped_reg;

endmodule

// File: tb/tb_wavelet_fir_mac.sv
// ---------------------------------------------------------------------------
// tb_wavelet_fir_mac
//   Directed and randomized stimulus for wavelet_fir_mac, checked against a
//   behavioural model: a delay line of integers, a latched coefficient set,
//   and sum/floor-shift/clamp done with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_wavelet_fir_mac;

  localparam int NT = 8;
  localparam int SW = 8;
  localparam int CW = 8;
  localparam int ST = 8;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wavelet_fir_mac_if #(
    .NUM_TAPS(NT), .SAMPLE_WIDTH(SW), .COEFF_WIDTH(CW), .SUM_TRUNCATION(ST)
  ) bus ();

  wavelet_fir_mac #(
    .NUM_TAPS(NT), .SAMPLE_WIDTH(SW), .COEFF_WIDTH(CW),
    .SUM_TRUNCATION(ST), .OUT_SHIFT(SH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  int m_x [NT];
  int m_c [NT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_x[k] = 0;
      m_c[k] = 0;
    end
  endtask

  task automatic model_accept(input int sample, input logic [NT*CW-1:0] coeffs);
    for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = sample;
    for (int k = 0; k < NT; k++) m_c[k] = int'($signed(coeffs[k*CW +: CW]));
  endtask

  function automatic int model_result();
    int s;
    int hi;
    int lo;
    s  = 0;
    hi = (1 << (ST - 1)) - 1;
    lo = -(1 << (ST - 1));
    for (int k = 0; k < NT; k++) s += m_x[k] * m_c[k];
    s = s >>> SH;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic accept(input int sample, input logic [NT*CW-1:0] coeffs);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", int'(ok), 1);
    bus.i_sample       = SW'(sample);
    bus.i_coeffs       = coeffs;
    bus.i_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
    acc_cyc = cyc;
    model_accept(sample, coeffs);
    $display("accept sample=%0d at cycle %0d", sample, acc_cyc);
  endtask

  task automatic get_result(input string tag, output int res);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        seen = 1'b1;
        break;
      end
    end
    res = int'(bus.o_truncated);
    chk({tag, "_valid"}, int'(seen), 1);
    chk({tag, "_lat"}, cyc - acc_cyc, NT);
    chk({tag, "_val"}, res, model_result());
    $display("result %s = %0d (latency %0d)", tag, res, cyc - acc_cyc);
  endtask

  function automatic logic [NT*CW-1:0] all_coeffs(input int v);
    logic [NT*CW-1:0] cv;
    for (int k = 0; k < NT; k++) cv[k*CW +: CW] = CW'(v);
    return cv;
  endfunction

  function automatic logic [NT*CW-1:0] tap0_coeff(input int v);
    logic [NT*CW-1:0] cv;
    cv = '0;
    cv[CW-1:0] = CW'(v);
    return cv;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int r;
    int nv;
    int s;
    logic [NT*CW-1:0] cv;

    model_reset();
    bus.i_sample       = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_coeffs       = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   int'(bus.o_ready), 1);
    chk("rst_busy",    int'(bus.o_busy), 0);
    chk("rst_valid",   int'(bus.o_valid), 0);
    chk("rst_dropped", int'(bus.o_dropped), 0);
    chk("rst_trunc",   int'(bus.o_truncated), 0);
    rst = 1'b1;

    // Impulse response: 127 then zeros, all taps 64.
    for (int i = 0; i < 10; i++) begin
      accept((i == 0) ? 127 : 0, all_coeffs(64));
      get_result("impulse", r);
      chk("impulse_const", r, (i < NT) ? 31 : 0);
    end

    // Positive then negative saturation.
    for (int i = 0; i < NT; i++) begin
      accept(127, all_coeffs(127));
      get_result("satpos", r);
    end
    chk("satpos_const", r, 127);
    for (int i = 0; i < NT; i++) begin
      accept(-128, all_coeffs(127));
      get_result("satneg", r);
    end
    chk("satneg_const", r, -128);

    // Floor rounding of the arithmetic shift.
    accept(-1, tap0_coeff(1));
    get_result("floor_neg", r);
    chk("floor_neg_const", r, -1);
    accept(1, tap0_coeff(1));
    get_result("floor_pos", r);
    chk("floor_pos_const", r, 0);

    // Sample offered during MAC is dropped.
    cv = {$urandom(), $urandom()};
    accept(int'($urandom_range(0, 255)) - 128, cv);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.i_sample       = 8'sd55;
    bus.i_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
    chk("drop_pulse", int'(bus.o_dropped), 1);
    chk("drop_ready", int'(bus.o_ready), 0);
    chk("drop_busy",  int'(bus.o_busy), 1);
    @(posedge clk);
    #1;
    chk("drop_once", int'(bus.o_dropped), 0);
    get_result("drop", r);

    // Coefficient change during MAC has no effect.
    accept(127, tap0_coeff(64));
    bus.i_coeffs = '0;
    get_result("coef_latch", r);
    chk("coef_latch_const", r, 31);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", int'(bus.o_valid), 0);

    // Reset in the middle of a MAC.
    accept(100, tap0_coeff(127));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("midrst_ready", int'(bus.o_ready), 1);
    chk("midrst_busy",  int'(bus.o_busy), 0);
    chk("midrst_valid", int'(bus.o_valid), 0);
    chk("midrst_trunc", int'(bus.o_truncated), 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    // All taps nonzero: any leftover 100 in the delay line would show up.
    accept(0, all_coeffs(127));
    get_result("after_rst", r);
    chk("after_rst_const", r, 0);

    // Randomized samples and coefficients, occasional dropped offers.
    for (int n = 0; n < 30; n++) begin
      s  = int'($urandom_range(0, 255)) - 128;
      cv = {$urandom(), $urandom()};
      accept(s, cv);
      if ($urandom_range(0, 3) == 0) begin
        bus.i_sample       = SW'($urandom());
        bus.i_sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_sample_valid = 1'b0;
        chk("rand_drop", int'(bus.o_dropped), 1);
      end
      get_result("rand", r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
